word_packer: RTL and testbench

- Parametrised sequential successor to the team's fixed 4+4→8 nibble concatenator. Accepts IN_W-bit words serially over a valid/ready stream and packs NUM_IN consecutive words into one IN_W*NUM_IN-bit output word.
- Ordering is selectable. A flush request emits a zero-padded partial word.
- Sits between narrow producers (switch/keypad nibble sources) and byte/word consumers (display drivers, UART TX).

---
 rtl/word_packer_pkg.sv | 16 +
 rtl/word_packer_if.sv | 29 ++
 rtl/word_packer_out_stage.sv | 34 +++
 rtl/word_packer.sv | 80 ++++++++
 tb/tb_word_packer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/word_packer_pkg.sv
// Shared helpers for the word_packer block: counter sizing and slot placement.
package word_packer_pkg;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // LSB position of the slot holding the k-th accepted word.
  function automatic int unsigned slot_lsb(input int unsigned k,
                                           input int unsigned in_w,
                                           input int unsigned num_in,
                                           input bit          msb_first);
    return msb_first ? (num_in - 1 - k) * in_w : k * in_w;
  endfunction

endpackage

// File: rtl/word_packer_if.sv
// Input stream, flush request and packed output stream of word_packer.
interface word_packer_if #(
  parameter int unsigned IN_W   = 4,
  parameter int unsigned NUM_IN = 2
);
  import word_packer_pkg::*;

  localparam int unsigned CW = cnt_width(NUM_IN);

  logic [IN_W-1:0]        in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   flush;
  logic [IN_W*NUM_IN-1:0] out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [CW-1:0]          out_count;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, out_count
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, out_count
  );

endinterface

// File: rtl/word_packer_out_stage.sv
// Valid/ready holding register for the packed word; a load may coincide with a drain.
module pack_out_stage #(
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic [CW-1:0]    load_count,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic [CW-1:0]    out_count,
  output logic             out_free
);

  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_count <= load_count;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/word_packer.sv
// Packs NUM_IN serial IN_W-bit words into one output word; flush emits a zero-padded partial.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int unsigned IN_W      = 4,
  parameter int unsigned NUM_IN    = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  word_packer_if.slave bus
);

  localparam int unsigned OUT_W = IN_W * NUM_IN;
  localparam int unsigned CW    = cnt_width(NUM_IN);
  localparam logic [CW-1:0] LAST = CW'(NUM_IN - 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_IN);

  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_ins;
  logic             flush_pend;
  logic             out_free;
  logic             accept;
  logic             complete;
  logic             emit_partial;
  logic             load;
  logic [OUT_W-1:0] load_data;
  logic [CW-1:0]    load_count;

  assign bus.in_ready = !rst && !flush_pend && (cnt < LAST || out_free);
  assign accept       = bus.in_valid && bus.in_ready;
  assign complete     = accept && (cnt == LAST);
  // in_ready is low while flush_pend is set, so a partial emit never races an accept.
  assign emit_partial = flush_pend && out_free && (cnt != '0);
  assign load         = complete || emit_partial;

  always_comb begin
    acc_ins    = acc | (OUT_W'(bus.in_data) << slot_lsb(32'(cnt), IN_W, NUM_IN, MSB_FIRST));
    load_data  = complete ? acc_ins : acc;
    load_count = complete ? FULL : cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (complete || emit_partial) begin
        cnt <= '0;
        acc <= '0;
      end else if (accept) begin
        cnt <= cnt + 1'b1;
        acc <= acc_ins;
      end
      if (bus.flush)
        flush_pend <= 1'b1;
      else if (flush_pend && (cnt == '0 || out_free))
        flush_pend <= 1'b0;
    end
  end

  pack_out_stage #(
    .OUT_W (OUT_W),
    .CW    (CW)
  ) u_out (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .load_count (load_count),
    .out_ready  (bus.out_ready),
    .out_data   (bus.out_data),
    .out_valid  (bus.out_valid),
    .out_count  (bus.out_count),
    .out_free   (out_free)
  );

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer: MSB/LSB ordering, backpressure, flush, NUM_IN=4 streaming, reset.
module tb_word_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  word_packer_if #(.IN_W(4), .NUM_IN(2)) ifa ();
  word_packer_if #(.IN_W(4), .NUM_IN(2)) ifb ();
  word_packer_if #(.IN_W(4), .NUM_IN(4)) ifc ();

  // ifb mirrors the stimulus of ifa so the LSB-first instance sees identical traffic.
  assign ifb.in_data   = ifa.in_data;
  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.flush     = ifa.flush;
  assign ifb.out_ready = ifa.out_ready;

  word_packer #(.IN_W(4), .NUM_IN(2), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  word_packer #(.IN_W(4), .NUM_IN(2), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  word_packer #(.IN_W(4), .NUM_IN(4), .MSB_FIRST(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ifa.out_valid); end
    n_checks++; if (ifa.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", ifa.out_data); end
    n_checks++; if (ifa.out_count !== 2'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", ifa.out_count); end
    n_checks++; if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", ifa.in_ready); end
    n_checks++; if (ifc.out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data_c got=%h exp=0000", ifc.out_data); end
    rst = 1'b0;
    step();
    n_checks++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", ifa.in_ready); end
  endtask

  task automatic test_ordering();
    ifa.out_ready = 1'b1;
    ifa.in_valid  = 1'b1;
    ifa.in_data   = 4'hA;
    step();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL order_early_valid got=%b exp=0", ifa.out_valid); end
    ifa.in_data = 4'hB;
    step();
    ifa.in_valid = 1'b0;
    n_checks++; if (ifa.out_data !== 8'hAB) begin n_fail++; $display("FAIL msb_data got=%h exp=ab", ifa.out_data); end
    n_checks++; if (ifa.out_count !== 2'd2) begin n_fail++; $display("FAIL msb_count got=%0d exp=2", ifa.out_count); end
    n_checks++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL msb_valid got=%b exp=1", ifa.out_valid); end
    n_checks++; if (ifb.out_data !== 8'hBA) begin n_fail++; $display("FAIL lsb_data got=%h exp=ba", ifb.out_data); end
    n_checks++; if (ifb.out_count !== 2'd2) begin n_fail++; $display("FAIL lsb_count got=%0d exp=2", ifb.out_count); end
    step();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL msb_valid_one_cycle got=%b exp=0", ifa.out_valid); end
    n_checks++; if (ifb.out_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_valid_one_cycle got=%b exp=0", ifb.out_valid); end
  endtask

  task automatic test_backpressure();
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_data   = 4'hA;
    step();
    ifa.in_data = 4'hB;
    step();
    ifa.in_data = 4'hC;
    step();
    ifa.in_data = 4'hD;
    #1;
    n_checks++; if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", ifa.in_ready); end
    step();
    n_checks++; if (ifa.out_data !== 8'hAB) begin n_fail++; $display("FAIL bp_hold_data got=%h exp=ab", ifa.out_data); end
    n_checks++; if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_hold got=%b exp=0", ifa.in_ready); end
    n_checks++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid got=%b exp=1", ifa.out_valid); end
    ifa.out_ready = 1'b1;
    step();
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b0;
    n_checks++; if (ifa.out_data !== 8'hCD) begin n_fail++; $display("FAIL bp_next_data got=%h exp=cd", ifa.out_data); end
    n_checks++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid got=%b exp=1", ifa.out_valid); end
    n_checks++; if (ifb.out_data !== 8'hDC) begin n_fail++; $display("FAIL bp_next_data_lsb got=%h exp=dc", ifb.out_data); end
    step();
    n_checks++; if (ifa.out_data !== 8'hCD) begin n_fail++; $display("FAIL bp_next_hold got=%h exp=cd", ifa.out_data); end
    ifa.out_ready = 1'b1;
    step();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid got=%b exp=0", ifa.out_valid); end
  endtask

  task automatic test_flush();
    ifa.out_ready = 1'b1;
    ifa.in_valid  = 1'b1;
    ifa.in_data   = 4'h5;
    step();
    ifa.in_valid = 1'b0;
    ifa.flush    = 1'b1;
    step();
    ifa.flush = 1'b0;
    n_checks++; if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pend_in_ready got=%b exp=0", ifa.in_ready); end
    step();
    n_checks++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid got=%b exp=1", ifa.out_valid); end
    n_checks++; if (ifa.out_data !== 8'h50) begin n_fail++; $display("FAIL flush_data got=%h exp=50", ifa.out_data); end
    n_checks++; if (ifa.out_count !== 2'd1) begin n_fail++; $display("FAIL flush_count got=%0d exp=1", ifa.out_count); end
    n_checks++; if (ifb.out_data !== 8'h05) begin n_fail++; $display("FAIL flush_data_lsb got=%h exp=05", ifb.out_data); end
    step();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drain got=%b exp=0", ifa.out_valid); end

    ifa.flush = 1'b1;
    step();
    ifa.flush = 1'b0;
    step();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid got=%b exp=0", ifa.out_valid); end
    n_checks++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty_in_ready got=%b exp=1", ifa.in_ready); end
    step();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid2 got=%b exp=0", ifa.out_valid); end

    ifa.in_valid = 1'b1;
    ifa.in_data  = 4'h5;
    step();
    ifa.in_data = 4'h6;
    ifa.flush   = 1'b1;
    step();
    ifa.in_valid = 1'b0;
    ifa.flush    = 1'b0;
    n_checks++; if (ifa.out_data !== 8'h56) begin n_fail++; $display("FAIL flush_full_data got=%h exp=56", ifa.out_data); end
    n_checks++; if (ifa.out_count !== 2'd2) begin n_fail++; $display("FAIL flush_full_count got=%0d exp=2", ifa.out_count); end
    step();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full_extra got=%b exp=0", ifa.out_valid); end
    step();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_full_extra2 got=%b exp=0", ifa.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_words [4];
    exp_words[0] = 16'h0123;
    exp_words[1] = 16'h4567;
    exp_words[2] = 16'h89AB;
    exp_words[3] = 16'hCDEF;
    ifc.out_ready = 1'b1;
    ifc.in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ifc.in_data = 4'(i);
      #1;
      n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, ifc.in_ready); end
      step();
      if (i % 4 == 3) begin
        n_checks++; if (ifc.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, ifc.out_valid); end
        n_checks++; if (ifc.out_data !== exp_words[i/4]) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, ifc.out_data, exp_words[i/4]); end
        n_checks++; if (ifc.out_count !== 3'd4) begin n_fail++; $display("FAIL b2b_count[%0d] got=%0d exp=4", i, ifc.out_count); end
      end else begin
        n_checks++; if (ifc.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[%0d] got=%b exp=0", i, ifc.out_valid); end
      end
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    ifa.out_ready = 1'b1;
    ifa.in_valid  = 1'b1;
    ifa.in_data   = 4'h3;
    step();
    ifa.in_valid = 1'b0;
    rst = 1'b1;
    step();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got=%b exp=0", ifa.out_valid); end
    n_checks++; if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_ready got=%b exp=0", ifa.in_ready); end
    rst = 1'b0;
    ifa.in_valid = 1'b1;
    ifa.in_data  = 4'h7;
    step();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale got=%b exp=0 data=%h", ifa.out_valid, ifa.out_data); end
    ifa.in_data = 4'h8;
    step();
    ifa.in_valid = 1'b0;
    n_checks++; if (ifa.out_data !== 8'h78) begin n_fail++; $display("FAIL rst_mid_data got=%h exp=78", ifa.out_data); end
    n_checks++; if (ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_out_valid got=%b exp=1", ifa.out_valid); end
    n_checks++; if (ifb.out_data !== 8'h87) begin n_fail++; $display("FAIL rst_mid_data_lsb got=%h exp=87", ifb.out_data); end
    step();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_single got=%b exp=0", ifa.out_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    ifa.in_data   = '0;
    ifa.in_valid  = 1'b0;
    ifa.flush     = 1'b0;
    ifa.out_ready = 1'b1;
    ifc.in_data   = '0;
    ifc.in_valid  = 1'b0;
    ifc.flush     = 1'b0;
    ifc.out_ready = 1'b1;
    #1;
    test_reset();
    test_ordering();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
